// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified-memory arbiter.
//   arb_state_e : FSM state encoding (IDLE/ISSUE/WAIT/DONE)
//   CNT_W       : width of the memory latency down-counter
//   STARVE_W    : width of the fetch-starvation counter
//   MEM_AW      : word-address width of the shared memory
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  localparam int CNT_W    = 3;
  localparam int STARVE_W = 4;
  localparam int MEM_AW   = 7;

endpackage

// File: rtl/regr.sv
// Generic holding register with synchronous clear.
//   clk   : clock
//   clear : synchronous clear (dominates hold)
//   hold  : 1 = keep q, 0 = load d
//   d     : data in
//   q     : registered data out
module regr #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             hold,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between an instruction-fetch
// port and a data port. One access is in flight at a time.
//   clk, reset                      : clock, synchronous active-high reset
//   if_req/if_addr                  : fetch request and byte address
//   if_ready/if_rdata               : fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata       : data request, write flag, address, data
//   d_ready/d_rdata                 : data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata: memory command (one ISSUE cycle)
//   mem_rdata                       : memory read data, valid LATENCY cycles
//                                     after the command
//
// state | meaning
// IDLE  | waiting for a request; arbitration happens here
// ISSUE | memory command on the bus for one cycle
// WAIT  | counting down the memory latency
// DONE  | ready pulse to the winner, rdata already captured
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [31:0]         if_addr,
  output logic                if_ready,
  output logic [31:0]         if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [31:0]         d_addr,
  input  logic [31:0]         d_wdata,
  output logic                d_ready,
  output logic [31:0]         d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [MEM_AW-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  localparam logic [CNT_W-1:0]    LAT_INIT   = CNT_W'(LATENCY - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e            state_q;
  logic [CNT_W-1:0]      wait_cnt_q;
  logic [STARVE_W-1:0]   starve_q;
  logic                  sel_data_q;
  logic                  is_write_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [MEM_AW-1:0]     mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  if_ready_q;
  logic                  d_ready_q;

  logic                  grant_data_d;
  logic [STARVE_W-1:0]   starve_d;
  logic                  rd_done;
  logic                  cap_if;
  logic                  cap_d;

  // Only word-address bits [8:2] reach the memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:9], if_addr[1:0], d_addr[31:9], d_addr[1:0]};

  // Data normally wins; a fetch that has lost STARVE_MAX times in a row wins.
  always_comb begin
    grant_data_d = d_req && !(if_req && (starve_q >= STARVE_LIM));
    starve_d     = '0;
    if (grant_data_d && if_req) begin
      starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      starve_q    <= '0;
      sel_data_q  <= 1'b0;
      is_write_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (if_req || d_req) begin
            state_q     <= ST_ISSUE;
            sel_data_q  <= grant_data_d;
            is_write_q  <= grant_data_d && d_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= grant_data_d && d_we;
            mem_addr_q  <= grant_data_d ? d_addr[8:2] : if_addr[8:2];
            mem_wdata_q <= grant_data_d ? d_wdata : '0;
            starve_q    <= starve_d;
          end
        end
        ST_ISSUE: begin
          wait_cnt_q <= LAT_INIT;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q    <= ST_DONE;
            if_ready_q <= !sel_data_q;
            d_ready_q  <= sel_data_q;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // rdata is sampled on the same edge that moves WAIT->DONE; writes never
  // disturb d_rdata.
  assign rd_done = (state_q == ST_WAIT) && (wait_cnt_q == '0);
  assign cap_if  = rd_done && !sel_data_q;
  assign cap_d   = rd_done && sel_data_q && !is_write_q;

  regr #(.WIDTH(32)) u_if_rdata (
    .clk   (clk),
    .clear (reset),
    .hold  (!cap_if),
    .d     (mem_rdata),
    .q     (if_rdata)
  );

  regr #(.WIDTH(32)) u_d_rdata (
    .clk   (clk),
    .clear (reset),
    .hold  (!cap_d),
    .d     (mem_rdata),
    .q     (d_rdata)
  );

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic [6:0]  mem_addr;

  // extra builds with LATENCY=1 and LATENCY=7 (fetch only)
  logic        l1_if_req, l7_if_req;
  logic [31:0] l_if_addr;
  logic        l_d_req, l_d_we;
  logic [31:0] l_d_addr, l_d_wdata;
  logic [31:0] l1_mem_rdata, l7_mem_rdata;
  logic        l1_if_ready, l7_if_ready, l1_d_ready, l7_d_ready;
  logic [31:0] l1_if_rdata, l7_if_rdata;
  logic [31:0] unused_l1_drdata, unused_l7_drdata, unused_l1_wdata, unused_l7_wdata;
  logic        l1_mem_en, l7_mem_en, l1_mem_we, l7_mem_we;
  logic [6:0]  l1_mem_addr, l7_mem_addr;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(1), .STARVE_MAX(SMAX)) u_l1 (
    .clk(clk), .reset(reset),
    .if_req(l1_if_req), .if_addr(l_if_addr), .if_ready(l1_if_ready), .if_rdata(l1_if_rdata),
    .d_req(l_d_req), .d_we(l_d_we), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
    .d_ready(l1_d_ready), .d_rdata(unused_l1_drdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(unused_l1_wdata),
    .mem_rdata(l1_mem_rdata)
  );

  mem_arbiter #(.LATENCY(7), .STARVE_MAX(SMAX)) u_l7 (
    .clk(clk), .reset(reset),
    .if_req(l7_if_req), .if_addr(l_if_addr), .if_ready(l7_if_ready), .if_rdata(l7_if_rdata),
    .d_req(l_d_req), .d_we(l_d_we), .d_addr(l_d_addr), .d_wdata(l_d_wdata),
    .d_ready(l7_d_ready), .d_rdata(unused_l7_drdata),
    .mem_en(l7_mem_en), .mem_we(l7_mem_we), .mem_addr(l7_mem_addr), .mem_wdata(unused_l7_wdata),
    .mem_rdata(l7_mem_rdata)
  );

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- memory environment ----------------
  logic [31:0] mem [128];
  int          cyc = 0;
  bit          hv [8];
  logic [6:0]  ha [8];
  int          l1_iss = -100;
  int          l7_iss = -100;

  always @(negedge clk) begin
    int p;
    hv[cyc % 8] = mem_en && !mem_we;
    ha[cyc % 8] = mem_addr;
    if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    p = (cyc + 8 - LAT) % 8;
    mem_rdata = (cyc >= LAT && hv[p]) ? mem[ha[p]] : $urandom;
    if (l1_mem_en) l1_iss = cyc;
    if (l7_mem_en) l7_iss = cyc;
    l1_mem_rdata = (cyc == l1_iss + 1) ? 32'hA1A1_0001 : $urandom;
    l7_mem_rdata = (cyc == l7_iss + 7) ? 32'hA7A7_0007 : $urandom;
  end

  // ---------------- behavioural model (transaction timeline) ----------------
  int          busy_until = 0;
  int          t_issue = -100;
  int          t_done  = -100;
  int          starve  = 0;
  bit          armed   = 0;
  bit          m_data, m_write;
  logic [6:0]  m_addr;
  logic [31:0] m_wdata, m_rd;
  bit          e_mem_en, e_mem_we, e_if_ready, e_d_ready;
  logic [6:0]  e_mem_addr;
  logic [31:0] e_mem_wdata, e_if_rdata, e_d_rdata;

  always @(posedge clk) begin
    int c;
    bit w;
    c = cyc;
    if (reset) begin
      armed = 1; busy_until = c + 1; t_issue = -100; t_done = -100; starve = 0;
      e_mem_en = 0; e_mem_we = 0; e_if_ready = 0; e_d_ready = 0;
      e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
    end else begin
      if (c >= busy_until && (if_req || d_req)) begin
        w = d_req && !(starve >= SMAX && if_req);
        starve = (w && if_req) ? ((starve < SMAX) ? starve + 1 : SMAX) : 0;
        m_data  = w;
        m_write = w && d_we;
        m_addr  = w ? d_addr[8:2] : if_addr[8:2];
        m_wdata = d_wdata;
        m_rd    = mem[m_addr];
        t_issue = c + 1;
        t_done  = c + LAT + 2;
        busy_until = c + LAT + 3;
      end
      e_mem_en = (c + 1 == t_issue);
      e_mem_we = e_mem_en && m_write;
      if (e_mem_en) begin
        e_mem_addr  = m_addr;
        e_mem_wdata = m_wdata;
      end
      e_if_ready = (c + 1 == t_done) && !m_data;
      e_d_ready  = (c + 1 == t_done) && m_data;
      if (e_if_ready) e_if_rdata = m_rd;
      if (e_d_ready && !m_write) e_d_rdata = m_rd;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("mem_en", mem_en, e_mem_en);
      chk("mem_we", mem_we, e_mem_we);
      chk("mem_addr", mem_addr, e_mem_addr);
      if (e_mem_we) chk("mem_wdata", mem_wdata, e_mem_wdata);
      chk("if_ready", if_ready, e_if_ready);
      chk("d_ready", d_ready, e_d_ready);
      chk("if_rdata", if_rdata, e_if_rdata);
      chk("d_rdata", d_rdata, e_d_rdata);
      chk("ready_exclusive", if_ready & d_ready, 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int g[$];
    int k;
    int r1, r7;
    reset = 1; if_req = 0; d_req = 0; d_we = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    l1_if_req = 0; l7_if_req = 0; l_if_addr = 32'h10;
    l_d_req = 0; l_d_we = 0; l_d_addr = '0; l_d_wdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[4]  = 32'h8C01_0010;
    mem[8]  = 32'h0BAD_C0DE;
    mem[16] = 32'h1234_5678;
    repeat (3) @(negedge clk);
    reset = 0;
    @(negedge clk);

    // single fetch
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    chk("t1_mem_en", mem_en, 1); chk("t1_mem_addr", mem_addr, 4); chk("t1_mem_we", mem_we, 0);
    repeat (2) @(negedge clk);
    chk("t1_no_early_ready", if_ready, 0);
    @(negedge clk);
    chk("t1_if_ready", if_ready, 1); chk("t1_if_rdata", if_rdata, 32'h8C01_0010);
    chk("t1_d_ready", d_ready, 0);
    if_req = 0;
    @(negedge clk);

    // simultaneous: data first, fetch after
    if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h20;
    @(negedge clk);
    chk("t2_mem_addr_data", mem_addr, 8);
    repeat (3) @(negedge clk);
    chk("t2_d_ready", d_ready, 1); chk("t2_d_rdata", d_rdata, 32'h0BAD_C0DE);
    chk("t2_if_ready_low", if_ready, 0);
    d_req = 0;
    repeat (2) @(negedge clk);
    chk("t2_mem_en_fetch", mem_en, 1); chk("t2_mem_addr_fetch", mem_addr, 16);
    repeat (3) @(negedge clk);
    chk("t2_if_ready", if_ready, 1); chk("t2_if_rdata", if_rdata, 32'h1234_5678);
    if_req = 0;
    @(negedge clk);

    // data write
    d_req = 1; d_we = 1; d_addr = 32'h7C; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("t3_mem_en", mem_en, 1); chk("t3_mem_we", mem_we, 1);
    chk("t3_mem_addr", mem_addr, 31); chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t3_mem_en_off", mem_en, 0); chk("t3_mem_we_off", mem_we, 0);
    repeat (2) @(negedge clk);
    chk("t3_d_ready", d_ready, 1); chk("t3_d_rdata_kept", d_rdata, 32'h0BAD_C0DE);
    chk("t3_mem_written", mem[31], 32'hDEAD_BEEF);
    d_req = 0; d_we = 0;
    @(negedge clk);

    // reset during WAIT
    if_req = 1; if_addr = 32'h10;
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("t4_if_ready", if_ready, 0); chk("t4_mem_en", mem_en, 0);
    chk("t4_mem_addr", mem_addr, 0); chk("t4_if_rdata", if_rdata, 0);
    chk("t4_d_rdata", d_rdata, 0); chk("t4_mem_wdata", mem_wdata, 0);
    repeat (4) @(negedge clk);
    chk("t4_if_ready_after", if_ready, 1); chk("t4_if_rdata_after", if_rdata, 32'h8C01_0010);
    if_req = 0;
    @(negedge clk);

    // starvation: both held high
    if_addr = 32'h100; d_addr = 32'h4; d_we = 0; if_req = 1; d_req = 1;
    k = 0;
    while (k < 200 && g.size() < 15) begin
      @(negedge clk);
      if (mem_en) g.push_back(int'(mem_addr));
      k++;
    end
    chk("t5_grant_count", g.size(), 15);
    foreach (g[i]) chk($sformatf("t5_grant%0d", i), g[i], (i % 5 == 4) ? 64 : 1);
    k = 0;
    while (!if_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_last_fetch_ready", if_ready, 1);
    if_req = 0; d_req = 0;
    @(negedge clk);

    // LATENCY=1 and LATENCY=7 builds
    l1_if_req = 1; l7_if_req = 1; r1 = -1; r7 = -1;
    for (int j = 1; j <= 14; j++) begin
      @(negedge clk);
      if (l1_mem_en) begin chk("l1_mem_addr", l1_mem_addr, 4); chk("l1_mem_we", l1_mem_we, 0); end
      if (l7_mem_en) begin chk("l7_mem_addr", l7_mem_addr, 4); chk("l7_mem_we", l7_mem_we, 0); end
      chk("lat_d_ready", {l1_d_ready, l7_d_ready}, 0);
      if (l1_if_ready && r1 < 0) begin
        r1 = j; l1_if_req = 0;
        chk("l1_if_rdata", l1_if_rdata, 32'hA1A1_0001);
      end
      if (l7_if_ready && r7 < 0) begin
        r7 = j; l7_if_req = 0;
        chk("l7_if_rdata", l7_if_rdata, 32'hA7A7_0007);
      end
    end
    chk("l1_ready_cycle", r1, 3);
    chk("l7_ready_cycle", r7, 9);

    // randomized traffic with occasional resets
    for (int j = 0; j < 3000; j++) begin
      @(negedge clk);
      if (reset) begin
        reset = 0;
      end else if ($urandom_range(0, 399) == 0) begin
        reset = 1; if_req = 0; d_req = 0;
      end
      if (!reset) begin
        if (if_req) begin
          if (if_ready) begin
            if ($urandom_range(0, 1) == 1) if_addr = $urandom;
            else if_req = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          if_req = 1; if_addr = $urandom;
        end
        if (d_req) begin
          if (d_ready) begin
            if ($urandom_range(0, 3) != 0) begin
              d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
            end else d_req = 0;
          end
        end else if ($urandom_range(0, 1) == 0) begin
          d_req = 1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
        end
      end
    end
    if_req = 0; d_req = 0; reset = 0;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
